// File: rtl/hilo_result_unit_pkg.sv
// Shared definitions for the HI/LO result unit: FSM encoding, producer
// indices and the default watchdog limit.
package hilo_result_unit_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    localparam int SRC_DIV         = 0;
    localparam int SRC_MULT        = 1;
    localparam int TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/result_select_mux.sv
// Indexed selector that picks one producer's done flag and HI/LO results
// out of the packed source buses.
module result_select_mux #(
    parameter int W    = 32,
    parameter int NSRC = 2,
    parameter int SELW = $clog2(NSRC)
) (
    input  logic [SELW-1:0]   sel,
    input  logic [NSRC-1:0]   src_done,
    input  logic [NSRC*W-1:0] src_hi,
    input  logic [NSRC*W-1:0] src_lo,
    output logic              done,
    output logic [W-1:0]      hi,
    output logic [W-1:0]      lo
);

    // Out-of-range selects resolve to zero with no done.
    always_comb begin
        done = 1'b0;
        hi   = '0;
        lo   = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (int'(sel) == i) begin
                done = src_done[i];
                hi   = src_hi[i*W +: W];
                lo   = src_lo[i*W +: W];
            end
        end
    end

endmodule

// File: rtl/hilo_result_unit.sv
// HI/LO register owner: waits for one multi-cycle producer at a time,
// handles mthi/mtlo, abort and a watchdog that flags a sticky error.
//
// state   | meaning
// --------+--------------------------------------------------------
// ST_IDLE | no operation in flight; mthi/mtlo and start accepted
// ST_WAIT | awaiting done from the latched source; counter running
module hilo_result_unit
    import hilo_result_unit_pkg::*;
#(
    parameter int W       = 32,
    parameter int NSRC    = 2,
    parameter int SELW    = $clog2(NSRC),
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CNTW    = $clog2(TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [SELW-1:0]   src_sel,
    input  logic              abort,
    input  logic [NSRC-1:0]   src_done,
    input  logic [NSRC*W-1:0] src_hi,
    input  logic [NSRC*W-1:0] src_lo,
    input  logic              mthi_we,
    input  logic              mtlo_we,
    input  logic [W-1:0]      mt_data,
    output logic [W-1:0]      hi_out,
    output logic [W-1:0]      lo_out,
    output logic              busy,
    output logic [CNTW-1:0]   last_lat,
    output logic              err
);

    localparam logic [CNTW-1:0] TIMEOUT_C = CNTW'(TIMEOUT);

    state_e            state_q, state_d;
    logic [SELW-1:0]   sel_q, sel_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]      hi_q, hi_d;
    logic [W-1:0]      lo_q, lo_d;
    logic [CNTW-1:0]   last_lat_q, last_lat_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;

    logic              sel_done;
    logic [W-1:0]      sel_hi;
    logic [W-1:0]      sel_lo;
    logic [CNTW-1:0]   cnt_inc;
    logic              sel_ok;
    logic              in_idle;
    logic              accept;
    logic              fin_abort;
    logic              fin_done;
    logic              fin_tmo;

    result_select_mux #(
        .W    (W),
        .NSRC (NSRC),
        .SELW (SELW)
    ) u_mux (
        .sel      (sel_q),
        .src_done (src_done),
        .src_hi   (src_hi),
        .src_lo   (src_lo),
        .done     (sel_done),
        .hi       (sel_hi),
        .lo       (sel_lo)
    );

    // Abort outranks done, which outranks the watchdog.
    assign cnt_inc   = cnt_q + 1'b1;
    assign sel_ok    = int'(src_sel) < NSRC;
    assign in_idle   = (state_q == ST_IDLE);
    assign accept    = in_idle && start && sel_ok;
    assign fin_abort = !in_idle && abort;
    assign fin_done  = !in_idle && !abort && sel_done;
    assign fin_tmo   = !in_idle && !abort && !sel_done && (cnt_inc == TIMEOUT_C);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_WAIT;
            ST_WAIT: if (fin_abort || fin_done || fin_tmo) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_d = (state_d == ST_WAIT);
    end

    always_comb begin
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        last_lat_d = last_lat_q;
        err_d      = err_q;
        if (in_idle) begin
            if (mthi_we) hi_d = mt_data;
            if (mtlo_we) lo_d = mt_data;
            if (start && !sel_ok) err_d = 1'b1;
            if (accept) begin
                sel_d = src_sel;
                cnt_d = '0;
            end
        end else if (fin_done) begin
            hi_d       = sel_hi;
            lo_d       = sel_lo;
            last_lat_d = cnt_inc;
        end else if (fin_tmo) begin
            err_d = 1'b1;
        end else if (!fin_abort) begin
            cnt_d = cnt_inc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_q      <= '0;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            last_lat_q <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            last_lat_q <= last_lat_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    assign hi_out   = hi_q;
    assign lo_out   = lo_q;
    assign busy     = busy_q;
    assign last_lat = last_lat_q;
    assign err      = err_q;

endmodule

// File: tb/tb_hilo_result_unit.sv
// Bench for hilo_result_unit: directed scenarios with literal expectations,
// then random traffic checked every cycle against a behavioural model.
module tb_hilo_result_unit;

    localparam int W       = 32;
    localparam int NSRC    = 2;
    localparam int SELW    = 1;
    localparam int TIMEOUT = 64;
    localparam int CNTW    = 7;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [SELW-1:0]   src_sel;
    logic              abort;
    logic [NSRC-1:0]   src_done;
    logic [NSRC*W-1:0] src_hi;
    logic [NSRC*W-1:0] src_lo;
    logic              mthi_we;
    logic              mtlo_we;
    logic [W-1:0]      mt_data;
    logic [W-1:0]      hi_out;
    logic [W-1:0]      lo_out;
    logic              busy;
    logic [CNTW-1:0]   last_lat;
    logic              err;

    int n_tests = 0;
    int n_fail  = 0;

    hilo_result_unit #(
        .W(W), .NSRC(NSRC), .SELW(SELW), .TIMEOUT(TIMEOUT), .CNTW(CNTW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .src_sel(src_sel),
        .abort(abort), .src_done(src_done), .src_hi(src_hi), .src_lo(src_lo),
        .mthi_we(mthi_we), .mtlo_we(mtlo_we), .mt_data(mt_data),
        .hi_out(hi_out), .lo_out(lo_out), .busy(busy),
        .last_lat(last_lat), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: an operation in flight plus how many WAIT cycles it has seen.
    logic [W-1:0] m_hi, m_lo;
    bit           m_busy, m_err;
    int           m_sel, m_age, m_lat;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_hi = '0; m_lo = '0; m_busy = 0; m_err = 0;
            m_sel = 0; m_age = 0; m_lat = 0;
        end else if (!m_busy) begin
            if (mthi_we) m_hi = mt_data;
            if (mtlo_we) m_lo = mt_data;
            if (start) begin
                if (int'(src_sel) < NSRC) begin
                    m_busy = 1; m_sel = int'(src_sel); m_age = 0;
                end else begin
                    m_err = 1;
                end
            end
        end else begin
            m_age++;
            if (abort) begin
                m_busy = 0;
            end else if (src_done[m_sel]) begin
                m_hi = src_hi[m_sel*W +: W];
                m_lo = src_lo[m_sel*W +: W];
                m_lat = m_age;
                m_busy = 0;
            end else if (m_age == TIMEOUT) begin
                m_err = 1;
                m_busy = 0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        check("cyc_hi",   64'(hi_out),   64'(m_hi));
        check("cyc_lo",   64'(lo_out),   64'(m_lo));
        check("cyc_busy", 64'(busy),     64'(m_busy));
        check("cyc_lat",  64'(last_lat), 64'(m_lat));
        check("cyc_err",  64'(err),      64'(m_err));
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        start = 0; abort = 0; src_done = '0;
        mthi_we = 0; mtlo_we = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        reset_n = 0; src_sel = '0; src_hi = '0; src_lo = '0; mt_data = '0;
        clear_inputs();
        repeat (3) tick();
        check("rst_hi",   64'(hi_out),   64'h0);
        check("rst_lo",   64'(lo_out),   64'h0);
        check("rst_busy", 64'(busy),     64'h0);
        check("rst_err",  64'(err),      64'h0);
        check("rst_lat",  64'(last_lat), 64'h0);
        reset_n = 1;
        tick();
        check("idle_busy", 64'(busy), 64'h0);

        // Source 1 completes on the third WAIT cycle.
        start = 1; src_sel = 1'b1;
        tick();
        start = 0;
        busy_cnt = 0;
        if (busy) busy_cnt++;
        tick();
        if (busy) busy_cnt++;
        tick();
        if (busy) busy_cnt++;
        src_done = 2'b10;
        src_hi = {32'hDEAD_BEEF, 32'h0};
        src_lo = {32'h0000_1234, 32'h0};
        tick();
        src_done = '0;
        check("t1_busy_cycles", 64'(busy_cnt), 64'd3);
        check("t1_hi",   64'(hi_out),   64'hDEAD_BEEF);
        check("t1_lo",   64'(lo_out),   64'h0000_1234);
        check("t1_lat",  64'(last_lat), 64'd3);
        check("t1_busy", 64'(busy),     64'h0);
        check("t1_model_hi", 64'(m_hi), 64'hDEAD_BEEF);

        // Non-selected done is ignored.
        start = 1; src_sel = 1'b0;
        tick();
        start = 0;
        src_done = 2'b10; src_hi = {32'h1111_1111, 32'h0}; src_lo = '0;
        tick();
        src_done = '0;
        tick();
        src_done = 2'b01; src_hi = {32'h0, 32'h0000_0005}; src_lo = {32'h0, 32'h0000_0002};
        tick();
        src_done = '0;
        check("t2_hi",  64'(hi_out),   64'h5);
        check("t2_lo",  64'(lo_out),   64'h2);
        check("t2_lat", 64'(last_lat), 64'd3);
        check("t2_model_lat", 64'(m_lat), 64'd3);

        // Watchdog.
        start = 1; src_sel = 1'b0;
        tick();
        start = 0;
        busy_cnt = 0;
        while (busy && busy_cnt < 200) begin
            busy_cnt++;
            tick();
        end
        check("t3_busy_cycles", 64'(busy_cnt), 64'd64);
        check("t3_err", 64'(err),    64'h1);
        check("t3_hi",  64'(hi_out), 64'h5);
        check("t3_lo",  64'(lo_out), 64'h2);
        check("t3_lat", 64'(last_lat), 64'd3);

        // mthi in IDLE, mtlo ignored in WAIT, abort.
        mthi_we = 1; mt_data = 32'hA5A5_0000;
        tick();
        mthi_we = 0;
        check("t4_mthi", 64'(hi_out), 64'hA5A5_0000);
        start = 1; src_sel = 1'b1;
        tick();
        start = 0;
        mtlo_we = 1; mt_data = 32'hFFFF_FFFF;
        tick();
        mtlo_we = 0;
        check("t4_mtlo_ignored", 64'(lo_out), 64'h2);
        abort = 1;
        tick();
        abort = 0;
        check("t4_abort_busy", 64'(busy),     64'h0);
        check("t4_abort_hi",   64'(hi_out),   64'hA5A5_0000);
        check("t4_abort_lo",   64'(lo_out),   64'h2);
        check("t4_abort_lat",  64'(last_lat), 64'd3);

        // Async reset in the middle of WAIT.
        start = 1; src_sel = 1'b1;
        tick();
        start = 0;
        tick();
        #2;
        reset_n = 0;
        #1;
        check("t5_rst_hi",   64'(hi_out),   64'h0);
        check("t5_rst_lo",   64'(lo_out),   64'h0);
        check("t5_rst_busy", 64'(busy),     64'h0);
        check("t5_rst_err",  64'(err),      64'h0);
        check("t5_rst_lat",  64'(last_lat), 64'h0);
        tick();
        reset_n = 1;
        src_done = 2'b10; src_hi = {32'h7777_7777, 32'h0}; src_lo = {32'h8888_8888, 32'h0};
        tick();
        src_done = '0;
        check("t5_late_done_hi",   64'(hi_out), 64'h0);
        check("t5_late_done_busy", 64'(busy),   64'h0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            start    = ($urandom_range(0, 3) == 0);
            src_sel  = SELW'($urandom_range(0, NSRC - 1));
            abort    = ($urandom_range(0, 31) == 0);
            src_done = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
            src_hi   = {$urandom, $urandom};
            src_lo   = {$urandom, $urandom};
            mthi_we  = ($urandom_range(0, 7) == 0);
            mtlo_we  = ($urandom_range(0, 7) == 0);
            mt_data  = $urandom;
            tick();
        end
        clear_inputs();
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hilo_result_unit.md
Name: hilo_result_unit

Overview:
- Parametrised successor to the two-way HI-source mux. It owns the HI and LO registers and accepts results from NSRC multi-cycle arithmetic producers (index 0 = div, 1 = mult by convention).
- Tracks one in-flight operation at a time. Exposes busy so the control FSM can stall mfhi/mflo.
- Supports direct mthi/mtlo writes, abort, and a watchdog timeout.
- Sits between the div/mult units and the mfhi/mflo datapath mux.

Parameters:
- W, 32, data width of HI, LO and each source result.
- NSRC, 2, number of result producers (≥2).
- SELW, $clog2(NSRC), width of the source select.
- TIMEOUT, 64, maximum WAIT cycles before the operation is abandoned (≥2).
- CNTW, $clog2(TIMEOUT+1), width of the latency counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse: operation issued to source src_sel.
- src_sel  in  SELW  producer whose completion is awaited.
- abort  in  1  cancel the in-flight operation.
- src_done  in  NSRC  per-source completion pulse.
- src_hi  in  NSRC*W  packed HI results; source i is at [i*W +: W].
- src_lo  in  NSRC*W  packed LO results; same packing.
- mthi_we  in  1  direct HI write.
- mtlo_we  in  1  direct LO write.
- mt_data  in  W  data for mthi/mtlo.
- hi_out  out  W  HI register.
- lo_out  out  W  LO register.
- busy  out  1  operation in flight; the controller stalls mfhi/mflo while high.
- last_lat  out  CNTW  WAIT cycles taken by the last completed operation.
- err  out  1  sticky: timeout or illegal src_sel.

Behaviour:
- Reset (async, reset_n=0): state=IDLE. hi_out, lo_out, last_lat, the counter and the latched select all = 0. busy=0, err=0. Reset mid-WAIT discards the operation; no write occurs.
- FSM states: IDLE, WAIT.
- In IDLE, start=1 with src_sel<NSRC: latch the select, clear the counter, move to WAIT. busy is high from the next cycle; busy is a registered function of state == WAIT.
- In IDLE, start=1 with src_sel≥NSRC: set err, remain in IDLE.
- In WAIT, on each cycle, in priority order:
  1. abort=1: go to IDLE, no write, last_lat unchanged.
  2. src_done[sel]=1: hi_out/lo_out ← src_hi/src_lo of the latched source at that edge; last_lat ← counter+1; go to IDLE.
  3. counter+1 == TIMEOUT: set err, go to IDLE, no write.
  4. Otherwise: increment the counter.
- In WAIT, src_done of a non-selected source is ignored.
- src_done is sampled only in WAIT. A done asserted in the same cycle as the accepting start is ignored.
- Minimum latency: done asserted in the first WAIT cycle gives last_lat=1. New HI/LO are visible the cycle after the done edge, and busy is low in that same cycle.
- start during WAIT is ignored; it causes no error and does not restart the operation.
- mthi_we/mtlo_we are honoured only in IDLE and take effect at the next edge. They are ignored in WAIT, since the pending result would overwrite them.
- Simultaneous mt write and start in IDLE: the mt write lands and the operation still starts.
- mthi_we and mtlo_we together write mt_data to both registers.
- err clears only on reset.

Decomposition:
- Shared package: FSM state encoding (IDLE=1'b0, WAIT=1'b1), a source-index constant per producer (SRC_DIV=0, SRC_MULT=1), and the default TIMEOUT.
- A generic parametrised one-hot/indexed mux, `result_select_mux` (W, NSRC), extracts the selected source's HI/LO. It is the natural single sub-module and supersedes the fixed 2x1 mux.
- The FSM, counter and registers stay in the top module.

Test Plan:
- Reset then idle → hi_out=0, lo_out=0, busy=0, err=0, last_lat=0.
- start, src_sel=1; src_done[1] on the 3rd WAIT cycle with hi=32'hDEAD_BEEF, lo=32'h0000_1234 → busy high for 3 cycles, then hi_out=DEADBEEF, lo_out=00001234, last_lat=3.
- start, src_sel=0; src_done[1] pulses with hi=32'h1111_1111, then src_done[0] with hi=32'h0000_0005, lo=32'h0000_0002 → the first pulse is ignored; hi_out=5, lo_out=2.
- start, src_sel=0 with no done (TIMEOUT=64) → busy for 64 cycles, then err=1, HI/LO unchanged.
- In IDLE: mthi_we with mt_data=32'hA5A5_0000 → hi_out=A5A50000. Then start; mtlo_we in WAIT with 32'hFFFF_FFFF → lo_out unchanged. Then abort → IDLE, no write.
- Assert reset_n=0 mid-WAIT (async, off-edge) → outputs 0 immediately. A later src_done is ignored.
